// File: rtl/booth_mul_seq.sv
// booth_mul_seq -- sequential radix-4 Booth multiplier behind 4-phase
// return-to-zero handshake channels.
//
// A transaction is started by activate_0r. Operands x and y are pulled over
// their own req/ack channels, the product is accumulated one Booth digit per
// clock, and the result is pushed on the z channel. activate_0a closes the
// transaction. Every incoming req/ack passes through a SYNC_STAGES flop chain
// before the control logic uses it.
//
// Build option:
//   BOOTH_SIGNED_EN  defined   -> two's complement operands/product,
//                                 WIDTH/2 multiply cycles
//                    undefined -> unsigned operands/product,
//                                 WIDTH/2+1 multiply cycles
//
// Parameters:
//   WIDTH        operand width (even, >= 4)
//   FULL_PRODUCT 1: z_0d is 2*WIDTH bits, 0: z_0d is the low WIDTH bits
//   SYNC_STAGES  synchroniser depth on incoming req/ack (>= 2)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   activate_0r/_0a       activation request (in) / acknowledge (out)
//   x_0r/_0a/_0d          operand x pull channel: req (out), ack/data (in)
//   y_0r/_0a/_0d          operand y pull channel: req (out), ack/data (in)
//   z_0r/_0a/_0d          result push channel: req/data (out), ack (in)

module booth_mul_seq #(
    parameter int WIDTH        = 16,
    parameter int FULL_PRODUCT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          activate_0r,
    output logic                                          activate_0a,
    output logic                                          x_0r,
    input  logic                                          x_0a,
    input  logic [WIDTH-1:0]                              x_0d,
    output logic                                          y_0r,
    input  logic                                          y_0a,
    input  logic [WIDTH-1:0]                              y_0d,
    output logic                                          z_0r,
    input  logic                                          z_0a,
    output logic [((FULL_PRODUCT != 0) ? 2*WIDTH : WIDTH)-1:0] z_0d
);

    localparam int ZW = (FULL_PRODUCT != 0) ? 2*WIDTH : WIDTH;
    localparam int AW = 2*WIDTH + 2;   // accumulator / multiplicand width
    localparam int YW = WIDTH + 3;     // extended multiplier plus the y[-1] bit
`ifdef BOOTH_SIGNED_EN
    localparam int NDIG = WIDTH/2;
`else
    // The zero-extended multiplier needs one extra digit so its top digit is
    // never read as negative.
    localparam int NDIG = WIDTH/2 + 1;
`endif
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MUL   = 3'd2,
        PUSH  = 3'd3,
        RTZ_Z = 3'd4,
        ACK   = 3'd5
    } state_t;

    // Extend x to accumulator width according to the build's number format.
    function automatic logic [AW-1:0] ext_x(input logic [WIDTH-1:0] v);
`ifdef BOOTH_SIGNED_EN
        ext_x = {{(AW-WIDTH){v[WIDTH-1]}}, v};
`else
        ext_x = {{(AW-WIDTH){1'b0}}, v};
`endif
    endfunction

    // Extend y by two bits and append the implicit y[-1] = 0 Booth bit.
    function automatic logic [YW-1:0] ext_y(input logic [WIDTH-1:0] v);
`ifdef BOOTH_SIGNED_EN
        ext_y = {{2{v[WIDTH-1]}}, v, 1'b0};
`else
        ext_y = {2'b00, v, 1'b0};
`endif
    endfunction

    // Radix-4 Booth partial product for one digit window {y[2i+1], y[2i], y[2i-1]}.
    function automatic logic [AW-1:0] booth_pp(input logic [2:0] win,
                                               input logic [AW-1:0] m);
        logic [AW-1:0] m2;
        m2 = {m[AW-2:0], 1'b0};
        case (win)
            3'b000, 3'b111: booth_pp = {AW{1'b0}};
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m2;
            3'b100:         booth_pp = {AW{1'b0}} - m2;
            3'b101, 3'b110: booth_pp = {AW{1'b0}} - m;
            default:        booth_pp = {AW{1'b0}};
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] act_sync_r;
    logic [SYNC_STAGES-1:0] xa_sync_r;
    logic [SYNC_STAGES-1:0] ya_sync_r;
    logic [SYNC_STAGES-1:0] za_sync_r;
    logic                   activate_0r_s;
    logic                   x_0a_s;
    logic                   y_0a_s;
    logic                   z_0a_s;

    state_t          state_r,  state_next;
    logic [AW-1:0]   mcand_r,  mcand_next;   // x, pre-shifted to the current digit weight
    logic [YW-1:0]   ysh_r,    ysh_next;     // y window register, low 3 bits = current digit
    logic [AW-1:0]   acc_r,    acc_next;
    logic [CW-1:0]   cnt_r,    cnt_next;
    logic            activate_0a_next;
    logic            x_0r_next;
    logic            y_0r_next;
    logic            z_0r_next;
    logic [ZW-1:0]   z_0d_next;
    logic [AW-1:0]   pp_s;
    logic [AW-1:0]   acc_sum_s;

    assign activate_0r_s = act_sync_r[SYNC_STAGES-1];
    assign x_0a_s        = xa_sync_r[SYNC_STAGES-1];
    assign y_0a_s        = ya_sync_r[SYNC_STAGES-1];
    assign z_0a_s        = za_sync_r[SYNC_STAGES-1];

    // Synchroniser chains for every incoming req/ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_sync_r <= {SYNC_STAGES{1'b0}};
            xa_sync_r  <= {SYNC_STAGES{1'b0}};
            ya_sync_r  <= {SYNC_STAGES{1'b0}};
            za_sync_r  <= {SYNC_STAGES{1'b0}};
        end else begin
            act_sync_r <= {act_sync_r[SYNC_STAGES-2:0], activate_0r};
            xa_sync_r  <= {xa_sync_r[SYNC_STAGES-2:0],  x_0a};
            ya_sync_r  <= {ya_sync_r[SYNC_STAGES-2:0],  y_0a};
            za_sync_r  <= {za_sync_r[SYNC_STAGES-2:0],  z_0a};
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mcand_r     <= {AW{1'b0}};
            ysh_r       <= {YW{1'b0}};
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            activate_0a <= 1'b0;
            x_0r        <= 1'b0;
            y_0r        <= 1'b0;
            z_0r        <= 1'b0;
            z_0d        <= {ZW{1'b0}};
        end else begin
            state_r     <= state_next;
            mcand_r     <= mcand_next;
            ysh_r       <= ysh_next;
            acc_r       <= acc_next;
            cnt_r       <= cnt_next;
            activate_0a <= activate_0a_next;
            x_0r        <= x_0r_next;
            y_0r        <= y_0r_next;
            z_0r        <= z_0r_next;
            z_0d        <= z_0d_next;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_next       = state_r;
        mcand_next       = mcand_r;
        ysh_next         = ysh_r;
        acc_next         = acc_r;
        cnt_next         = cnt_r;
        activate_0a_next = activate_0a;
        x_0r_next        = x_0r;
        y_0r_next        = y_0r;
        z_0r_next        = z_0r;
        z_0d_next        = z_0d;
        pp_s             = booth_pp(ysh_r[2:0], mcand_r);
        acc_sum_s        = acc_r + pp_s;

        case (state_r)
            IDLE: begin
                if (activate_0r_s) begin
                    state_next = FETCH;
                    x_0r_next  = 1'b1;
                    y_0r_next  = 1'b1;
                    acc_next   = {AW{1'b0}};
                    cnt_next   = {CW{1'b0}};
                end else begin
                    state_next = IDLE;
                end
            end

            FETCH: begin
                // The two operand channels complete independently.
                if (x_0r && x_0a_s) begin
                    x_0r_next  = 1'b0;
                    mcand_next = ext_x(x_0d);
                end else begin
                    x_0r_next  = x_0r;
                end
                if (y_0r && y_0a_s) begin
                    y_0r_next = 1'b0;
                    ysh_next  = ext_y(y_0d);
                end else begin
                    y_0r_next = y_0r;
                end
                if (!x_0r && !y_0r && !x_0a_s && !y_0a_s) begin
                    state_next = MUL;
                end else begin
                    state_next = FETCH;
                end
            end

            MUL: begin
                acc_next   = acc_sum_s;
                mcand_next = {mcand_r[AW-3:0], 2'b00};
                // Arithmetic shift; the unsigned build's top bits are zero anyway.
                ysh_next   = {{2{ysh_r[YW-1]}}, ysh_r[YW-1:2]};
                cnt_next   = cnt_r + 1'b1;
                if (cnt_r == LAST_DIG) begin
                    // Load the result now; z_0r follows a cycle later so the
                    // data is stable before the request is seen.
                    state_next = PUSH;
                    z_0d_next  = acc_sum_s[ZW-1:0];
                end else begin
                    state_next = MUL;
                end
            end

            PUSH: begin
                // z_0r is low only on the first PUSH cycle.
                if (!z_0r) begin
                    z_0r_next = 1'b1;
                end else if (z_0a_s) begin
                    z_0r_next  = 1'b0;
                    state_next = RTZ_Z;
                end else begin
                    z_0r_next  = 1'b1;
                end
            end

            RTZ_Z: begin
                if (!z_0a_s) begin
                    state_next       = ACK;
                    activate_0a_next = 1'b1;
                end else begin
                    state_next = RTZ_Z;
                end
            end

            ACK: begin
                // If activate was already withdrawn this yields a one-cycle pulse.
                if (!activate_0r_s) begin
                    activate_0a_next = 1'b0;
                    state_next       = IDLE;
                end else begin
                    activate_0a_next = 1'b1;
                end
            end

            default: begin
                state_next       = IDLE;
                activate_0a_next = 1'b0;
                x_0r_next        = 1'b0;
                y_0r_next        = 1'b0;
                z_0r_next        = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq (WIDTH=16). A full-product instance and a
// low-half instance share all stimulus; the bench acts as the environment on
// every handshake channel. Expected products are hand-computed constants for
// both the unsigned and BOOTH_SIGNED_EN builds, pushed into a scoreboard when
// a transaction starts and popped by a monitor when z_0r rises.

module tb_booth_mul_seq;

    localparam int W = 16;
`ifdef BOOTH_SIGNED_EN
    localparam int NDIG = W/2;
`else
    localparam int NDIG = W/2 + 1;
`endif
    // Negedges from the last operand-ack drop to z_0r high:
    // 2 sync stages, FETCH exit, NDIG multiply cycles, one setup cycle.
    localparam int LAT = 2 + 2 + NDIG;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          activate_0r = 1'b0;
    logic          x_0a = 1'b0;
    logic          y_0a = 1'b0;
    logic          z_0a = 1'b0;
    logic [W-1:0]  x_0d = 16'h0000;
    logic [W-1:0]  y_0d = 16'h0000;

    logic          activate_0a, x_0r, y_0r, z_0r;
    logic [2*W-1:0] z_0d;
    logic          lo_activate_0a, lo_x_0r, lo_y_0r, lo_z_0r;
    logic [W-1:0]  lo_z_0d;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] full;
        logic [15:0] low;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          xd;
        int          yd;
        int          zd;
        bit          drop;
        logic [31:0] uexp;
        logic [31:0] sexp;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W), .FULL_PRODUCT(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .activate_0r(activate_0r), .activate_0a(activate_0a),
        .x_0r(x_0r), .x_0a(x_0a), .x_0d(x_0d),
        .y_0r(y_0r), .y_0a(y_0a), .y_0d(y_0d),
        .z_0r(z_0r), .z_0a(z_0a), .z_0d(z_0d)
    );

    booth_mul_seq #(.WIDTH(W), .FULL_PRODUCT(0), .SYNC_STAGES(2)) dut_lo (
        .clk(clk), .rst_n(rst_n),
        .activate_0r(activate_0r), .activate_0a(lo_activate_0a),
        .x_0r(lo_x_0r), .x_0a(x_0a), .x_0d(x_0d),
        .y_0r(lo_y_0r), .y_0a(y_0a), .y_0d(y_0d),
        .z_0r(lo_z_0r), .z_0a(z_0a), .z_0d(lo_z_0d)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       get_sig = x_0r;
            1:       get_sig = y_0r;
            2:       get_sig = z_0r;
            3:       get_sig = activate_0a;
            default: get_sig = 1'b0;
        endcase
    endfunction

    // Bounded wait (sampled on negedges) for a DUT output to reach a level.
    task automatic wait_sig(input int sel, input logic val, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (get_sig(sel) == val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no level %0b expected within 2000 cycles", nm, val);
        end
    endtask

    // Environment side of one operand pull channel.
    task automatic feed(input int ch, input logic [15:0] d, input int dly);
        wait_sig(ch, 1'b1, (ch == 0) ? "x_req_hi" : "y_req_hi");
        repeat (dly) @(negedge clk);
        if (ch == 0) begin x_0d = d; x_0a = 1'b1; end
        else         begin y_0d = d; y_0a = 1'b1; end
        wait_sig(ch, 1'b0, (ch == 0) ? "x_req_lo" : "y_req_lo");
        if (ch == 0) begin x_0a = 1'b0; x_0d = 16'hDEAD; end
        else         begin y_0a = 1'b0; y_0d = 16'hBEEF; end
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        int   n;
        int   pulse;
`ifdef BOOTH_SIGNED_EN
        e.full = v.sexp;
`else
        e.full = v.uexp;
`endif
        e.low = e.full[15:0];
        sb_q.push_back(e);

        @(negedge clk);
        activate_0r = 1'b1;
        fork
            feed(0, v.x, v.xd);
            feed(1, v.y, v.yd);
        join

        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (v.drop && n == 5) activate_0r = 1'b0;
            if (z_0r) break;
        end
        chk("latency", n, LAT);

        repeat (v.zd) @(negedge clk);
        z_0a = 1'b1;
        wait_sig(2, 1'b0, "z_req_lo");
        z_0a = 1'b0;

        wait_sig(3, 1'b1, "act_ack_hi");
        if (!v.drop) begin
            repeat (3) @(negedge clk);
            chk("ack_hold", {31'd0, activate_0a}, 32'd1);
            activate_0r = 1'b0;
            wait_sig(3, 1'b0, "act_ack_lo");
        end else begin
            pulse = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (activate_0a) pulse++;
                else break;
            end
            chk("ack_pulse_len", pulse, 32'd1);
        end
        chk("z_hold", z_0d, e.full);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: compares both products whenever z_0r rises.
    initial begin
        exp_t e;
        logic z_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (z_0r && !z_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_z: got z_0d %h expected no push", z_0d);
                end else begin
                    e = sb_q.pop_front();
                    chk("z_full", z_0d, e.full);
                    chk("z_low", {16'd0, lo_z_0d}, {16'd0, e.low});
                    chk("lo_z_req", {31'd0, lo_z_0r}, 32'd1);
                end
            end
            z_prev = z_0r;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected within 2000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              x         y         xd  yd  zd  drop  unsigned       signed
        vecs[0]  = '{16'd10000, 16'd3,     0,  0,  0,  1'b0, 32'd30000,     32'd30000};
        vecs[1]  = '{16'd3,     16'd10000, 0,  0,  0,  1'b0, 32'd30000,     32'd30000};
        vecs[2]  = '{16'hFFFF,  16'hFFFF,  0,  0,  0,  1'b0, 32'hFFFE0001,  32'h00000001};
        vecs[3]  = '{16'h8000,  16'h8000,  0,  0,  0,  1'b0, 32'h40000000,  32'h40000000};
        vecs[4]  = '{16'd10000, 16'd10,    0,  0,  0,  1'b0, 32'h000186A0,  32'h000186A0};
        vecs[5]  = '{16'h0000,  16'h1234,  0,  0,  0,  1'b0, 32'h00000000,  32'h00000000};
        vecs[6]  = '{16'h1234,  16'h0000,  0,  0,  0,  1'b0, 32'h00000000,  32'h00000000};
        vecs[7]  = '{16'h8000,  16'h0001,  0,  0,  0,  1'b0, 32'h00008000,  32'hFFFF8000};
        vecs[8]  = '{16'h7FFF,  16'h7FFF,  0,  0,  0,  1'b0, 32'h3FFF0001,  32'h3FFF0001};
        vecs[9]  = '{16'hFFFF,  16'h0002,  0,  0,  0,  1'b0, 32'h0001FFFE,  32'hFFFFFFFE};
        vecs[10] = '{16'h8000,  16'h7FFF,  7,  0,  0,  1'b0, 32'h3FFF8000,  32'hC0008000};
        vecs[11] = '{16'd10000, 16'd3,     0,  20, 50, 1'b1, 32'd30000,     32'd30000};
        vecs[12] = '{16'hFFFE,  16'hFFFD,  0,  0,  3,  1'b0, 32'hFFFB0006,  32'h00000006};
        vecs[13] = '{16'hFFFF,  16'hFFFF,  0,  0,  0,  1'b0, 32'hFFFE0001,  32'h00000001};

        // Reset state.
        #12;
        chk("rst_act_ack", {31'd0, activate_0a}, 32'd0);
        chk("rst_x_req",   {31'd0, x_0r}, 32'd0);
        chk("rst_z_req",   {31'd0, z_0r}, 32'd0);
        chk("rst_z_data",  z_0d, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 13; i++) run_txn(vecs[i]);

        // Reset asserted in the middle of a multiply.
        @(negedge clk);
        activate_0r = 1'b1;
        fork
            feed(0, 16'h1234, 0);
            feed(1, 16'h0005, 0);
        join
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_act_ack", {31'd0, activate_0a}, 32'd0);
        chk("mid_rst_x_req",   {31'd0, x_0r}, 32'd0);
        chk("mid_rst_y_req",   {31'd0, y_0r}, 32'd0);
        chk("mid_rst_z_req",   {31'd0, z_0r}, 32'd0);
        chk("mid_rst_z_data",  z_0d, 32'd0);
        chk("mid_rst_lo_out",  {12'd0, lo_activate_0a, lo_x_0r, lo_y_0r, lo_z_0r, lo_z_0d}, 32'd0);
        activate_0r = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", {31'd0, x_0r}, 32'd0);

        run_txn(vecs[13]);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; even, >= 4.
REQ-002 SHALL have parameter FULL_PRODUCT, default 1: 1 gives a ZW=2*WIDTH product, 0 gives ZW=WIDTH (low bits).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on every incoming req/ack, >= 2.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 activate_0r  in  1  activation request.
REQ-008 activate_0a  out  1  activation acknowledge.
REQ-009 x_0r  out  1  pull request for operand x.
REQ-010 x_0a  in  1  acknowledge for x; x_0d is valid while high.
REQ-011 x_0d  in  WIDTH  operand x.
REQ-012 y_0r, y_0a, y_0d  out/in/in  1/1/WIDTH  operand y channel, identical to x.
REQ-013 z_0r  out  1  push request for the result.
REQ-014 z_0a  in  1  result acknowledge.
REQ-015 z_0d  out  ZW  product.

Function
REQ-016 SHALL use 4-phase return-to-zero handshakes on all channels; incoming activate_0r, x_0a, y_0a and z_0a SHALL be used only after the SYNC_STAGES flop chain (suffix _s).
REQ-017 SHALL implement FSM states IDLE, FETCH, MUL, PUSH, RTZ_Z, ACK.
REQ-018 IDLE: when activate_0r_s=1, SHALL go to FETCH and raise x_0r and y_0r on the same edge.
REQ-019 FETCH: each channel SHALL capture its data on the edge where its ack_s is first seen high, and drop its req on that same edge; channels are independent and may complete in either order.
REQ-020 FETCH SHALL go to MUL once both reqs are low and x_0a_s=y_0a_s=0.
REQ-021 MUL SHALL retire one radix-4 Booth digit of y per cycle.
- Signed build: WIDTH/2 cycles.
- Unsigned build: WIDTH/2+1 cycles, using zero-extended operands.
- Accumulator: 2*WIDTH+2 bits.
REQ-022 On MUL exit, SHALL load z_0d with the product, or its low WIDTH bits when FULL_PRODUCT=0, and raise z_0r one cycle later (one cycle of data setup).
REQ-023 PUSH: on z_0a_s=1, SHALL drop z_0r and go to RTZ_Z; RTZ_Z: on z_0a_s=0, SHALL go to ACK.
REQ-024 ACK: SHALL hold activate_0a=1 until activate_0r_s=0, then drop activate_0a and go to IDLE.
- If activate_0r_s is already 0, activate_0a SHALL pulse for exactly one cycle.
REQ-025 Deassertion of activate_0r before ACK SHALL be ignored; the transaction SHALL complete.
REQ-026 z_0d SHALL hold its value from load until the next load or reset.
REQ-027 x_0r, y_0r and z_0r SHALL be glitch-free register outputs.
REQ-028 A 0 operand SHALL yield 0.
REQ-029 The most negative operand SHALL multiply correctly in both builds; there is no overflow flag.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and clear all outputs, captured operands, accumulator and synchronisers, including mid-transaction.
REQ-031 After rst_n rises, the block SHALL act only on a fresh activate_0r_s=1.

Configuration
REQ-032 With BOOTH_SIGNED_EN defined, operands and product SHALL be two's complement and MUL SHALL take WIDTH/2 cycles.
REQ-033 Without BOOTH_SIGNED_EN, operands and product SHALL be unsigned and MUL SHALL take WIDTH/2+1 cycles.

Verification
REQ-034 WIDTH=16, full, unsigned: x=10000, y=3 -> z_0d=30000; then x=3, y=10000 -> 30000; activate_0a completes both transactions.
REQ-035 Unsigned, x=y=0xFFFF -> z_0d=0xFFFE0001; same operands with BOOTH_SIGNED_EN -> 0x00000001; signed x=y=0x8000 -> 0x40000000.
REQ-036 FULL_PRODUCT=0: x=10000, y=10 -> z_0d=34464 (low 16 bits of 100000).
REQ-037 Signed build: count edges from the FETCH exit to z_0r rising -> exactly WIDTH/2+1 (9 for WIDTH=16); unsigned build -> WIDTH/2+2 (10).
REQ-038 y_0a delayed 20 cycles after x_0a; z_0a delayed 50 cycles; activate_0r dropped during MUL -> correct product and a single one-cycle activate_0a pulse.
REQ-039 rst_n pulsed low during MUL -> all req/ack outputs and z_0d=0 within the reset pulse; the next activation gives a correct product.
